mult_arbiter: RTL
=================

# mult_arbiter

Round-robin arbiter and sequencer that shares one sequential `mult` datapath among `NREQ` requesters. It accepts operand pairs over per-requester valid/ready channels and drives the multiplier's start/operand inputs. It waits on the multiplier's busy handshake and returns each product, tagged with the requester index, on a single shared response channel. It sits between the client blocks and the single `mult` instance, which is external to this block.

## Interface
- `N`, 16, operand width; product width is 2*N.
- `NREQ`, 4, number of requesters, 2..16.
- `TIMEOUT`, 1024, watchdog limit in cycles; used only when the timeout feature is compiled in.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_ready`  out  NREQ  per-requester accept; at most one bit set (one-hot or zero).
- `req_a`  in  NREQ*N  operand a; requester i uses bits [i*N +: N].
- `req_b`  in  NREQ*N  operand b; same packing as `req_a`.
- `resp_valid`  out  1  response valid.
- `resp_ready`  in  1  response accept.
- `resp_id`  out  ID_W  index of the requester that owns the response; ID_W = max(1, $clog2(NREQ)).
- `resp_product`  out  2*N  product.
- `resp_err`  out  1  timeout flag.
- `mult_start`  out  1  start pulse to the multiplier.
- `mult_a`, `mult_b`  out  N  operands to the multiplier.
- `mult_product`  in  2*N  multiplier result.
- `mult_busy`  in  1  multiplier busy.

## Operation
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP.
- **IDLE**
  - Grants only when some `req_valid` bit is high and `mult_busy`=0.
  - Grant g is the first valid index found searching from `last+1`, wrapping modulo NREQ.
  - `req_ready[g]`=1 combinationally in the same cycle, completing the handshake.
  - On that edge: capture `req_a`/`req_b` slice g into the operand registers, set `id`=g, set `last`=g, go to ISSUE.
- **ISSUE**
  - `mult_start`=1 for exactly this one cycle, then go to WAIT_BUSY.
  - `mult_a`/`mult_b` come from the operand registers and stay stable from ISSUE through RESP.
- **WAIT_BUSY**: stay until `mult_busy`=1 is sampled, then go to WAIT_DONE.
- **WAIT_DONE**: stay until `mult_busy`=0 is sampled. On that edge capture `mult_product` into `resp_product`, then go to RESP.
- **RESP**
  - `resp_valid`=1 and `resp_id`=id.
  - Holds until `resp_valid && resp_ready`, then returns to IDLE.
  - `resp_*` outputs are stable while stalled.
- Only one operation is in flight at a time. Requests that are not granted keep waiting; no request is dropped.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,…,NREQ-1,0.
- Reset values:
  - State = IDLE, `last` = NREQ-1 (so requester 0 wins first).
  - `req_ready`=0, `resp_valid`=0, `resp_id`=0, `resp_product`=0, `resp_err`=0.
  - `mult_start`=0, `mult_a`=0, `mult_b`=0.
- Reset mid-operation aborts it and produces no response. Any multiplier operation still running is drained by the IDLE rule that waits for `mult_busy`=0 before granting.

## Timing
- Request accepted at cycle 0 → `mult_start` high at cycle 1.
- If busy rises at cycle 2 and falls, as sampled, at cycle 2+L → `resp_valid` high at cycle 3+L.
- Minimum turnaround from response accept to the next grant: 1 cycle (RESP → IDLE, grant in IDLE).
- `req_ready` depends combinationally on `req_valid` and `mult_busy` only, never on `resp_ready`.
- `resp_valid` never rises and falls without a handshake.

## Configuration
- Macro `MULT_ARBITER_TIMEOUT_EN`.
- **Defined**
  - A cycle counter runs across WAIT_BUSY and WAIT_DONE.
  - When it reaches TIMEOUT, go to RESP with `resp_err`=1 and `resp_product`=0.
  - The counter clears on entry to ISSUE.
- **Undefined**
  - No counter is built and `resp_err` is tied to 0.
  - The FSM waits indefinitely on `mult_busy`.

## Structure
- Package `mult_arbiter_pkg` holds:
  - the state enum `mult_arb_state_t`;
  - the ID_W computation, as a function `id_width(nreq)`.
- One sub-module, `rr_pick`: a parameterized round-robin picker.
  - Inputs: request vector and `last` pointer.
  - Outputs: one-hot grant, encoded index, `any` flag.
  - Purely combinational.
- The multiplier is not instantiated here; the bench connects it, or a behavioural model of it.

## Test plan
- Single request: requester 2 sends a=300, b=7 → one `mult_start` pulse; response `resp_id`=2, `resp_product`=2100, `resp_err`=0.
- All four requesters valid, operands (i+1, 10) → responses in id order 0,1,2,3 with products 10,20,30,40; `req_ready` is one-hot each time.
- `resp_ready` held low 5 cycles with a=0xFFFF, b=0xFFFF → `resp_product`=0xFFFE0001 stable throughout; no new grant until the handshake.
- `mult_busy` forced high at reset release with requester 0 valid → no `req_ready` until busy drops, then normal grant.
- Assert `reset` during WAIT_DONE → all outputs zero the next cycle; after release requester 0 wins first and its response is correct.
- With `MULT_ARBITER_TIMEOUT_EN` and TIMEOUT=16, `mult_busy` stuck high → `resp_valid` with `resp_err`=1 and product 0 after 16 cycles. Without the macro, no response appears within 100 cycles.

Source files
------------

// File: rtl/mult_arbiter_pkg.sv
// Shared types and helpers for the mult_arbiter slice.
// Optional watchdog is enabled by defining MULT_ARBITER_TIMEOUT_EN.
package mult_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        RESP
    } mult_arb_state_t;

    function automatic int id_width(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/mult_arbiter_if.sv
// Request, response and multiplier-side signals of mult_arbiter.
// master = the arbiter, slave = clients plus the external multiplier.
interface mult_arbiter_if
    import mult_arbiter_pkg::*;
#(
    parameter int N    = 16,
    parameter int NREQ = 4
);
    localparam int ID_W = id_width(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_a;
    logic [NREQ*N-1:0] req_b;

    logic              resp_valid;
    logic              resp_ready;
    logic [ID_W-1:0]   resp_id;
    logic [2*N-1:0]    resp_product;
    logic              resp_err;

    logic              mult_start;
    logic [N-1:0]      mult_a;
    logic [N-1:0]      mult_b;
    logic [2*N-1:0]    mult_product;
    logic              mult_busy;

    modport master (
        input  req_valid, req_a, req_b, resp_ready,
        input  mult_product, mult_busy,
        output req_ready, resp_valid, resp_id, resp_product, resp_err,
        output mult_start, mult_a, mult_b
    );

    modport slave (
        output req_valid, req_a, req_b, resp_ready,
        output mult_product, mult_busy,
        input  req_ready, resp_valid, resp_id, resp_product, resp_err,
        input  mult_start, mult_a, mult_b
    );

endinterface

// File: rtl/mult_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after `last`,
// wrapping modulo NREQ.
module rr_pick
    import mult_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int ID_W = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] last,
    output logic [NREQ-1:0] gnt,
    output logic [ID_W-1:0] idx,
    output logic            any
);

    int j;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            j = (int'(last) + k) % NREQ;
            if (!any && req[j]) begin
                gnt[j] = 1'b1;
                idx    = ID_W'(j);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin sequencer sharing one external sequential multiplier.
// Define MULT_ARBITER_TIMEOUT_EN to build the busy-wait watchdog.
module mult_arbiter
    import mult_arbiter_pkg::*;
#(
    parameter int N       = 16,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          reset,
    mult_arbiter_if.master bus
);

    localparam int ID_W = id_width(NREQ);

    if (NREQ < 2 || NREQ > 16 || TIMEOUT < 1) begin : g_param_chk
        $error("mult_arbiter: unsupported parameters");
    end

    mult_arb_state_t state_q, state_d;

    logic [ID_W-1:0] last_q, id_q, pick_idx;
    logic [NREQ-1:0] pick_gnt;
    logic            pick_any;
    logic [N-1:0]    a_q, b_q;
    logic [2*N-1:0]  prod_q;
    logic            grant, done, tmo, expired;

    rr_pick #(.NREQ(NREQ), .ID_W(ID_W)) u_pick (
        .req  (bus.req_valid),
        .last (last_q),
        .gnt  (pick_gnt),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    assign grant = (state_q == IDLE) && pick_any && !bus.mult_busy;
    assign done  = (state_q == WAIT_DONE) && !bus.mult_busy;
    assign tmo   = (state_q == WAIT_BUSY || state_q == WAIT_DONE)
                   && expired && !done;

`ifdef MULT_ARBITER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             err_q;

    // Counts wait cycles; fires on the TIMEOUT-th one.
    assign expired = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_q == ISSUE)
                cnt_q <= '0;
            else if (state_q == WAIT_BUSY || state_q == WAIT_DONE)
                cnt_q <= cnt_q + 1'b1;
            if (done)
                err_q <= 1'b0;
            else if (tmo)
                err_q <= 1'b1;
        end
    end

    assign bus.resp_err = err_q;
`else
    assign expired      = 1'b0;
    assign bus.resp_err = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        bus.req_ready  = '0;
        bus.mult_start = 1'b0;
        bus.resp_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    bus.req_ready = pick_gnt;
                    state_d       = ISSUE;
                end
            end
            ISSUE: begin
                bus.mult_start = 1'b1;
                state_d        = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (expired)
                    state_d = RESP;
                else if (bus.mult_busy)
                    state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (done || expired)
                    state_d = RESP;
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                if (bus.resp_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= ID_W'(NREQ - 1);
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                a_q    <= bus.req_a[pick_idx*N +: N];
                b_q    <= bus.req_b[pick_idx*N +: N];
                id_q   <= pick_idx;
                last_q <= pick_idx;
            end
            if (done)
                prod_q <= bus.mult_product;
            else if (tmo)
                prod_q <= '0;
        end
    end

    assign bus.mult_a       = a_q;
    assign bus.mult_b       = b_q;
    assign bus.resp_id      = id_q;
    assign bus.resp_product = prod_q;

endmodule
